// File: rtl/adc_test_pattern_gen.sv
// AD9643-style output-path test-pattern generator: picks normal conversion data
// or one of the register 0x0D test patterns and registers it toward the DDR pins.
module adc_test_pattern_gen #(
  parameter int          DATA_W    = 14,
  parameter int          PAT_W     = 16,
  parameter logic [8:0]  PN9_SEED  = 9'h1FF,
  parameter logic [22:0] PN23_SEED = 23'h7FFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] normal_data,
  input  logic [3:0]        select_mode,
  input  logic              reset_PN_short_gen,
  input  logic              reset_PN_long_gen,
  input  logic              user_test_mode_control,
  input  logic [PAT_W-1:0]  user_pattern_1,
  input  logic [PAT_W-1:0]  user_pattern_2,
  input  logic [PAT_W-1:0]  user_pattern_3,
  input  logic [PAT_W-1:0]  user_pattern_4,
  output logic [DATA_W-1:0] output_test_mode_reg
);

  localparam logic [3:0] MODE_NORMAL  = 4'b0000;
  localparam logic [3:0] MODE_MID     = 4'b0001;
  localparam logic [3:0] MODE_POS_FS  = 4'b0010;
  localparam logic [3:0] MODE_NEG_FS  = 4'b0011;
  localparam logic [3:0] MODE_CHECKER = 4'b0100;
  localparam logic [3:0] MODE_PN23    = 4'b0101;
  localparam logic [3:0] MODE_PN9     = 4'b0110;
  localparam logic [3:0] MODE_TOGGLE  = 4'b0111;
  localparam logic [3:0] MODE_USER    = 4'b1000;
  localparam logic [3:0] MODE_RAMP    = 4'b1111;

  localparam logic [DATA_W-1:0] MIDSCALE  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] POS_FS    = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] NEG_FS    = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] CHECKER_A = {(DATA_W/2){2'b10}};
  localparam logic [DATA_W-1:0] CHECKER_B = {(DATA_W/2){2'b01}};

  logic [8:0]        pn9;
  logic [22:0]       pn23;
  logic [DATA_W-1:0] ramp;
  logic              phase;
  logic [1:0]        user_idx;
  logic              user_done;

  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] user_word;
  logic [DATA_W-1:0] pn9_word;
  logic [DATA_W-1:0] pn23_word;

  // Patterns are MSB-aligned; the low PAT_W-DATA_W bits never reach the pins.
  logic unused_pattern_bits;
  assign unused_pattern_bits = ^{user_pattern_1[PAT_W-DATA_W-1:0],
                                 user_pattern_2[PAT_W-DATA_W-1:0],
                                 user_pattern_3[PAT_W-DATA_W-1:0],
                                 user_pattern_4[PAT_W-DATA_W-1:0]};

  assign pn9_word  = DATA_W'({pn9, pn9[8:4]});
  assign pn23_word = pn23[22 -: DATA_W];

  always_comb begin
    user_word = user_pattern_4[PAT_W-1 -: DATA_W];
    if (!user_done) begin
      case (user_idx)
        2'd0:    user_word = user_pattern_1[PAT_W-1 -: DATA_W];
        2'd1:    user_word = user_pattern_2[PAT_W-1 -: DATA_W];
        2'd2:    user_word = user_pattern_3[PAT_W-1 -: DATA_W];
        default: user_word = user_pattern_4[PAT_W-1 -: DATA_W];
      endcase
    end
  end

  always_comb begin
    sel_data = normal_data;
    case (select_mode)
      MODE_NORMAL:  sel_data = normal_data;
      MODE_MID:     sel_data = MIDSCALE;
      MODE_POS_FS:  sel_data = POS_FS;
      MODE_NEG_FS:  sel_data = NEG_FS;
      MODE_CHECKER: sel_data = phase ? CHECKER_B : CHECKER_A;
      MODE_PN23:    sel_data = pn23_word;
      MODE_PN9:     sel_data = pn9_word;
      MODE_TOGGLE:  sel_data = phase ? NEG_FS : POS_FS;
      MODE_USER:    sel_data = user_word;
      MODE_RAMP:    sel_data = ramp;
      default:      sel_data = normal_data;
    endcase
  end

  // Output register; it samples the generators before their own update this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_test_mode_reg <= '0;
    end else begin
      output_test_mode_reg <= sel_data;
    end
  end

  // Phase, ramp and both LFSRs free-run regardless of the selected mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      ramp  <= '0;
      pn9   <= PN9_SEED;
      pn23  <= PN23_SEED;
    end else begin
      phase <= ~phase;
      ramp  <= ramp + 1'b1;
      if (reset_PN_short_gen) begin
        pn9 <= PN9_SEED;
      end else begin
        pn9 <= {pn9[7:0], pn9[8] ^ pn9[4]};
      end
      if (reset_PN_long_gen) begin
        pn23 <= PN23_SEED;
      end else begin
        pn23 <= {pn23[21:0], pn23[22] ^ pn23[17]};
      end
    end
  end

  // User sequencer: leaving user mode rewinds to pattern 1; in single-pass
  // mode it parks on pattern 4 once that word has been output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      user_idx  <= 2'd0;
      user_done <= 1'b0;
    end else if (select_mode != MODE_USER) begin
      user_idx  <= 2'd0;
      user_done <= 1'b0;
    end else if (!user_done) begin
      if (user_test_mode_control && user_idx == 2'd3) begin
        user_done <= 1'b1;
      end else begin
        user_idx <= user_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_adc_test_pattern_gen.sv
// Directed bench for adc_test_pattern_gen: one task per feature, inline checks,
// expected values from hand-computed constants and a small LFSR model.
module tb_adc_test_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] normal_data;
  logic [3:0]  select_mode;
  logic        reset_PN_short_gen;
  logic        reset_PN_long_gen;
  logic        user_test_mode_control;
  logic [15:0] user_pattern_1;
  logic [15:0] user_pattern_2;
  logic [15:0] user_pattern_3;
  logic [15:0] user_pattern_4;
  logic [13:0] output_test_mode_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_test_pattern_gen dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .normal_data            (normal_data),
    .select_mode            (select_mode),
    .reset_PN_short_gen     (reset_PN_short_gen),
    .reset_PN_long_gen      (reset_PN_long_gen),
    .user_test_mode_control (user_test_mode_control),
    .user_pattern_1         (user_pattern_1),
    .user_pattern_2         (user_pattern_2),
    .user_pattern_3         (user_pattern_3),
    .user_pattern_4         (user_pattern_4),
    .output_test_mode_reg   (output_test_mode_reg)
  );

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    select_mode = 4'b0000;
    normal_data = 14'h1234;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (output_test_mode_reg !== 14'h0000) begin
      errors++;
      $display("FAIL reset_async: got %h expected 0000", output_test_mode_reg);
    end
    @(posedge clk); #1;
    checks++;
    if (output_test_mode_reg !== 14'h0000) begin
      errors++;
      $display("FAIL reset_held: got %h expected 0000", output_test_mode_reg);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (output_test_mode_reg !== 14'h1234) begin
      errors++;
      $display("FAIL normal_first: got %h expected 1234", output_test_mode_reg);
    end
    normal_data = 14'h0ABC;
    @(posedge clk); #1;
    checks++;
    if (output_test_mode_reg !== 14'h0ABC) begin
      errors++;
      $display("FAIL normal_second: got %h expected 0abc", output_test_mode_reg);
    end
  endtask

  task automatic test_fixed_modes();
    logic [3:0]  modes [9]  = '{4'b0001, 4'b0010, 4'b0011, 4'b1001, 4'b1010,
                                4'b1011, 4'b1100, 4'b1101, 4'b1110};
    logic [13:0] exps  [9]  = '{14'h2000, 14'h3FFF, 14'h0000, 14'h0ABC, 14'h0ABC,
                                14'h0ABC, 14'h0ABC, 14'h0ABC, 14'h0ABC};
    for (int i = 0; i < 9; i++) begin
      select_mode = modes[i];
      @(posedge clk); #1;
      checks++;
      if (output_test_mode_reg !== exps[i]) begin
        errors++;
        $display("FAIL fixed_mode_%b: got %h expected %h", modes[i], output_test_mode_reg, exps[i]);
      end
    end
  endtask

  task automatic test_checker_toggle();
    logic [13:0] exp;
    select_mode = 4'b0100;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 14'h2AAA : 14'h1555;
      @(posedge clk); #1;
      checks++;
      if (output_test_mode_reg !== exp) begin
        errors++;
        $display("FAIL checker_%0d: got %h expected %h", i, output_test_mode_reg, exp);
      end
    end
    select_mode = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 14'h3FFF : 14'h0000;
      @(posedge clk); #1;
      checks++;
      if (output_test_mode_reg !== exp) begin
        errors++;
        $display("FAIL toggle_%0d: got %h expected %h", i, output_test_mode_reg, exp);
      end
    end
  endtask

  task automatic test_pn9();
    logic [8:0]  m;
    logic [13:0] exp;
    logic [13:0] first_two [2] = '{14'h3FFF, 14'h3FDF};
    select_mode = 4'b0110;
    reset_PN_short_gen = 1'b1;
    @(posedge clk); #1;
    reset_PN_short_gen = 1'b0;
    m = 9'h1FF;
    for (int k = 0; k < 516; k++) begin
      exp = {m, m[8:4]};
      @(posedge clk); #1;
      checks++;
      if (output_test_mode_reg !== exp) begin
        errors++;
        $display("FAIL pn9_step_%0d: got %h expected %h", k, output_test_mode_reg, exp);
      end
      if (k == 0 || k == 1 || k == 511 || k == 512) begin
        checks++;
        if (output_test_mode_reg !== first_two[k % 511]) begin
          errors++;
          $display("FAIL pn9_const_%0d: got %h expected %h", k, output_test_mode_reg, first_two[k % 511]);
        end
      end
      m = {m[7:0], m[8] ^ m[4]};
    end
  endtask

  task automatic test_pn23();
    logic [22:0] m;
    logic [13:0] exp;
    select_mode = 4'b0101;
    reset_PN_long_gen = 1'b1;
    @(posedge clk); #1;
    reset_PN_long_gen = 1'b0;
    m = 23'h7FFFFF;
    for (int k = 0; k < 60; k++) begin
      exp = m[22:9];
      @(posedge clk); #1;
      checks++;
      if (output_test_mode_reg !== exp) begin
        errors++;
        $display("FAIL pn23_step_%0d: got %h expected %h", k, output_test_mode_reg, exp);
      end
      if (k == 0) begin
        checks++;
        if (output_test_mode_reg !== 14'h3FFF) begin
          errors++;
          $display("FAIL pn23_first: got %h expected 3fff", output_test_mode_reg);
        end
      end
      m = {m[21:0], m[22] ^ m[17]};
    end
  endtask

  task automatic test_user();
    logic [13:0] single [6] = '{14'd1, 14'd2, 14'd3, 14'd4, 14'd4, 14'd4};
    logic [13:0] exp;
    user_pattern_1 = 16'h0004;
    user_pattern_2 = 16'h0008;
    user_pattern_3 = 16'h000C;
    user_pattern_4 = 16'h0010;
    user_test_mode_control = 1'b0;
    select_mode = 4'b1000;
    for (int i = 0; i < 9; i++) begin
      exp = 14'((i % 4) + 1);
      @(posedge clk); #1;
      checks++;
      if (output_test_mode_reg !== exp) begin
        errors++;
        $display("FAIL user_cont_%0d: got %h expected %h", i, output_test_mode_reg, exp);
      end
    end
    select_mode = 4'b0000;
    normal_data = 14'h0111;
    @(posedge clk); #1;
    user_test_mode_control = 1'b1;
    select_mode = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (output_test_mode_reg !== single[i]) begin
        errors++;
        $display("FAIL user_single_%0d: got %h expected %h", i, output_test_mode_reg, single[i]);
      end
    end
    user_pattern_4 = 16'h0020;
    @(posedge clk); #1;
    checks++;
    if (output_test_mode_reg !== 14'd8) begin
      errors++;
      $display("FAIL user_live: got %h expected 0008", output_test_mode_reg);
    end
    select_mode = 4'b0001;
    @(posedge clk); #1;
    select_mode = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      exp = 14'(i + 1);
      @(posedge clk); #1;
      checks++;
      if (output_test_mode_reg !== exp) begin
        errors++;
        $display("FAIL user_reenter_%0d: got %h expected %h", i, output_test_mode_reg, exp);
      end
    end
  endtask

  task automatic test_ramp();
    int e;
    select_mode = 4'b1111;
    apply_reset();
    e = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; e++;
      checks++;
      if (output_test_mode_reg !== 14'(e - 1)) begin
        errors++;
        $display("FAIL ramp_start_%0d: got %h expected %h", i, output_test_mode_reg, 14'(e - 1));
      end
    end
    select_mode = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; e++;
      checks++;
      if (output_test_mode_reg !== 14'h2000) begin
        errors++;
        $display("FAIL ramp_away_%0d: got %h expected 2000", i, output_test_mode_reg);
      end
    end
    select_mode = 4'b1111;
    @(posedge clk); #1; e++;
    checks++;
    if (output_test_mode_reg !== 14'd8) begin
      errors++;
      $display("FAIL ramp_kept_running: got %h expected 0008", output_test_mode_reg);
    end
    while (e < 16384) begin
      @(posedge clk); e++;
    end
    #1;
    checks++;
    if (output_test_mode_reg !== 14'h3FFF) begin
      errors++;
      $display("FAIL ramp_top: got %h expected 3fff", output_test_mode_reg);
    end
    @(posedge clk); #1;
    checks++;
    if (output_test_mode_reg !== 14'h0000) begin
      errors++;
      $display("FAIL ramp_wrap: got %h expected 0000", output_test_mode_reg);
    end
    @(posedge clk); #1;
    checks++;
    if (output_test_mode_reg !== 14'h0001) begin
      errors++;
      $display("FAIL ramp_after_wrap: got %h expected 0001", output_test_mode_reg);
    end
  endtask

  task automatic test_async_reset();
    select_mode = 4'b1111;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (output_test_mode_reg !== 14'h0000) begin
      errors++;
      $display("FAIL async_mid_ramp: got %h expected 0000", output_test_mode_reg);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (output_test_mode_reg !== 14'(i)) begin
        errors++;
        $display("FAIL ramp_restart_%0d: got %h expected %h", i, output_test_mode_reg, 14'(i));
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    normal_data = '0;
    select_mode = '0;
    reset_PN_short_gen = 1'b0;
    reset_PN_long_gen = 1'b0;
    user_test_mode_control = 1'b0;
    user_pattern_1 = '0;
    user_pattern_2 = '0;
    user_pattern_3 = '0;
    user_pattern_4 = '0;
    test_reset();
    test_fixed_modes();
    test_checker_toggle();
    test_pn9();
    test_pn23();
    test_user();
    test_ramp();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_test_pattern_gen.md
Name: adc_test_pattern_gen

Overview:
- 14-bit ADC output-path test-pattern generator for the AD9643 behavioural model.
- Sits between the normal conversion data and the DDR output pins.
- Selects normal data or one of the AD9643 register 0x0D test patterns: midscale, full-scale, checkerboard, PN9/PN23, toggle, user patterns, ramp.
- Selection comes from SPI-written mode bits; output is registered.

Parameters:
- DATA_W, 14, output/normal data width.
- PAT_W, 16, user pattern width; the PAT_W-DATA_W low bits are dropped.
- PN9_SEED, 9'h1FF, PN9 LFSR seed.
- PN23_SEED, 23'h7FFFFF, PN23 LFSR seed.

Ports:
- clk  input  1  output sample clock (rising edge).
- rst_n  input  1  asynchronous active-low reset.
- normal_data  input  14  ADC conversion data, offset binary.
- select_mode  input  4  test-mode select (reg 0x0D[3:0]).
- reset_PN_short_gen  input  1  hold PN9 at seed while high.
- reset_PN_long_gen  input  1  hold PN23 at seed while high.
- user_test_mode_control  input  1  0 = continuous user sequence; 1 = single pass.
- user_pattern_1  input  16  user pattern word 1.
- user_pattern_2  input  16  user pattern word 2.
- user_pattern_3  input  16  user pattern word 3.
- user_pattern_4  input  16  user pattern word 4.
- output_test_mode_reg  output  14  registered selected data.

Behaviour:
- Reset (rst_n low, async) sets:
  - output_test_mode_reg = 0x0000.
  - PN9 = PN9_SEED, PN23 = PN23_SEED.
  - ramp = 0, phase flop = 0.
  - user index = 0, user-done = 0.
- Output is registered. Each rising clk loads the value chosen by the select_mode present before the edge, using generator state before that edge's update. Latency is 1 cycle.
- Mode map (value loaded on each clk):
  - 0000: normal_data.
  - 0001: 0x2000 (midscale).
  - 0010: 0x3FFF (+FS).
  - 0011: 0x0000 (-FS).
  - 0100: checkerboard, 0x2AAA when phase=0, 0x1555 when phase=1.
  - 0101: PN23, equal to pn23[22:9].
  - 0110: PN9, equal to {pn9[8:0], pn9[8:4]}.
  - 0111: one/zero toggle, 0x3FFF when phase=0, 0x0000 when phase=1.
  - 1000: user pattern, user_pattern_N[15:2] with N = index+1.
  - 1111: ramp counter value.
  - 1001-1110: unused, pass normal_data.
- Phase flop toggles every clk, free-running in all modes.
- Ramp is a 14-bit counter that increments every clk in all modes. It wraps 0x3FFF -> 0x0000.
- PN9 update:
  - Each clk: pn9 <= {pn9[7:0], pn9[8]^pn9[4]}.
  - While reset_PN_short_gen is high, pn9 <= PN9_SEED instead (synchronous).
  - Free-running in all modes.
- PN23 update:
  - Each clk: pn23 <= {pn23[21:0], pn23[22]^pn23[17]}.
  - While reset_PN_long_gen is high, pn23 <= PN23_SEED instead.
  - Free-running in all modes.
- User mode index:
  - The index advances 0->1->2->3 once per clk while select_mode==1000.
  - control=0: index wraps 3->0 and the 1,2,3,4 sequence repeats forever.
  - control=1: after pattern 4 has been output, user-done is set. While done, the output holds pattern 4.
  - When select_mode!=1000, index=0 and user-done=0. Re-entering user mode therefore restarts at pattern 1.
- User patterns are sampled live each cycle; they are not latched.
- Mode changes take effect on the next edge. No glitch or flush cycles.
- Reset asserted mid-sequence returns all state to the reset values immediately.

Test Plan:
- Reset, then mode 0000 with normal_data=0x1234: output 0x0000 during reset, then 0x1234 one clk after the first edge.
- Modes 0001/0010/0011: output 0x2000, 0x3FFF, 0x0000. Mode 0100 from reset: 0x2AAA, 0x1555, 0x2AAA alternating. Mode 0111: 0x3FFF, 0x0000 alternating.
- PN9 check: mode 0110, pulse reset_PN_short_gen high for 1 clk, then release.
  - First output after release = 0x3FFF, next = 0x3FDF.
  - Sequence period is 511.
  - Same procedure for PN23: first output 0x3FFF, period 2^23-1 (spot-check against the reference LFSR model).
- User continuous: mode 1000, control=0, patterns 0x0004/0x0008/0x000C/0x0010 -> outputs 1,2,3,4,1,2,... Repeat with control=1 -> 1,2,3,4,4,4... Leave and re-enter mode 1000 -> restarts at 1.
- Ramp: mode 1111 -> output increments by 1 per clk; wraps 0x3FFF -> 0x0000. Switching 1111 -> 0001 -> 1111 shows the counter kept running.
- Async reset asserted mid-ramp, between clock edges -> output 0x0000 immediately. After release, ramp restarts from 0.
